// File: rtl/apb_reg_pkg.sv
// -----------------------------------------------------------------------------
// apb_reg_pkg
// Shared types and constants for the APB register slave:
//   - apb_state_e : bus-side FSM states (IDLE, ACCESS)
//   - apb_dec_t   : address decode result (index, hit, misaligned, ro_violation)
//   - WAIT_W      : width of the access-phase wait-state counter
//   - dec_error() : collapses a decode result into the PSLVERR condition
// -----------------------------------------------------------------------------
package apb_reg_pkg;

  // Wait-state counter width; supports WAIT_CYCLES in 0..15.
  localparam int WAIT_W = 4;

  // Fixed index width inside the decode struct. Packages cannot be
  // parameterised, so the index is carried wide and zero-extended; 16 bits
  // covers any ADDR_W up to 18.
  localparam int DEC_IDX_W = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  typedef struct packed {
    logic [DEC_IDX_W-1:0] index;         // register index, 0 when !hit
    logic                 hit;           // address falls inside the register window
    logic                 misaligned;    // PADDR[1:0] != 0
    logic                 ro_violation;  // write aimed at a read-only register
  } apb_dec_t;

  // Any single condition produces an error response.
  function automatic logic dec_error(input apb_dec_t d);
    return d.misaligned | ~d.hit | d.ro_violation;
  endfunction

endpackage

// File: rtl/apb_reg_decode.sv
// -----------------------------------------------------------------------------
// apb_reg_decode
// Combinational APB address decode and error classification.
//
// Parameters:
//   ADDR_W    - PADDR width
//   NUM_REGS  - number of word registers in the window
//   BASE_ADDR - word-aligned byte address of register 0
//   RO_MASK   - bit i set marks register i as read-only
//
// Ports:
//   i_paddr  in   ADDR_W  byte address from the bus
//   i_pwrite in   1       transfer direction (1 = write)
//   o_dec    out  struct  decode result (index, hit, misaligned, ro_violation)
// -----------------------------------------------------------------------------
module apb_reg_decode
  import apb_reg_pkg::*;
#(
  parameter int                  ADDR_W    = 12,
  parameter int                  NUM_REGS  = 8,
  parameter int unsigned         BASE_ADDR = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic              i_pwrite,
  output apb_dec_t          o_dec
);

  // Work in 32-bit word-address space so the subtraction and range compare
  // never truncate, whatever ADDR_W and NUM_REGS are.
  localparam logic [31:0] BASE_WORD  = BASE_ADDR >> 2;
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  logic [31:0] w_word;
  logic [31:0] w_diff;
  logic        w_below;
  logic        w_in_range;
  logic        w_ro_bit;

  assign w_word     = 32'(i_paddr[ADDR_W-1:2]);
  assign w_below    = (w_word < BASE_WORD);
  assign w_diff     = w_word - BASE_WORD;
  assign w_in_range = !w_below && (w_diff < NUM_REGS_U);

  // Look the RO bit up by comparison rather than by indexing RO_MASK with
  // w_diff, which could point past the mask for out-of-window addresses.
  // NOTE: every signal written in an always_comb gets a default first;
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    w_ro_bit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_diff == 32'(i) && RO_MASK[i]) w_ro_bit = 1'b1;
    end
  end

  always_comb begin
    o_dec              = '0;
    o_dec.hit          = w_in_range;
    o_dec.index        = w_in_range ? DEC_IDX_W'(w_diff) : '0;
    o_dec.misaligned   = (i_paddr[1:0] != 2'b00);
    o_dec.ro_violation = i_pwrite & w_ro_bit;
  end

endmodule

// File: rtl/apb_reg_slave.sv
// -----------------------------------------------------------------------------
// apb_reg_slave
// APB slave fronting NUM_REGS contiguous word registers. RW registers drive
// configuration outputs (reg_q); RO registers return live hw_status. Decode
// errors (misaligned, out of window, write to RO) answer with PSLVERR and have
// no side effects. WAIT_CYCLES access-phase wait states precede PREADY.
//
// Optional feature (compile-time macro APB_REG_SLAVE_PSTRB_EN):
//   adds PSTRB; writes update only strobed bytes, PSTRB=0 is a pulsing no-op.
//   Without the macro every write updates the full word.
//
// Ports:
//   PCLK       in   1                APB clock
//   PRESETn    in   1                asynchronous active-low reset
//   PSEL       in   1                slave select
//   PENABLE    in   1                access phase
//   PWRITE     in   1                1 = write, 0 = read
//   PADDR      in   ADDR_W           byte address
//   PWDATA     in   DATA_W           write data
//   PSTRB      in   DATA_W/8         byte strobes (only with the macro)
//   PRDATA     out  DATA_W           read data; 0 unless PREADY && !PWRITE
//   PREADY     out  1                transfer completion
//   PSLVERR    out  1                error response, qualified by PREADY
//   hw_status  in   NUM_REGS*DATA_W  values returned for RO registers
//   reg_q      out  NUM_REGS*DATA_W  RW register contents (RO slots read 0)
//   wr_pulse   out  NUM_REGS         one-cycle pulse per written register
// -----------------------------------------------------------------------------
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int                  ADDR_W      = 12,
  parameter int                  DATA_W      = 32,
  parameter int                  NUM_REGS    = 8,
  parameter int unsigned         BASE_ADDR   = 0,
  parameter int                  WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic [DATA_W-1:0]          PWDATA,
`ifdef APB_REG_SLAVE_PSTRB_EN
  input  logic [DATA_W/8-1:0]        PSTRB,
`endif
  output logic [DATA_W-1:0]          PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  input  logic [NUM_REGS*DATA_W-1:0] hw_status,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int                NB        = DATA_W / 8;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  apb_state_e           r_state;
  logic [WAIT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]    r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]  r_wr_pulse;

  apb_dec_t             w_dec;
  logic                 w_err;
  logic                 w_access;
  logic                 w_done;
  logic                 w_commit;
  logic [NUM_REGS-1:0]  w_sel;
  logic [DATA_W-1:0]    w_rdata;
  logic [NB-1:0]        w_strb;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  apb_reg_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .RO_MASK   (RO_MASK)
  ) u_decode (
    .i_paddr  (PADDR),
    .i_pwrite (PWRITE),
    .o_dec    (w_dec)
  );

  assign w_err = dec_error(w_dec);

`ifdef APB_REG_SLAVE_PSTRB_EN
  assign w_strb = PSTRB;
`else
  assign w_strb = '1;
`endif

  // One-hot select of the addressed register; all zero outside the window.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_dec.hit && (w_dec.index == DEC_IDX_W'(i))) w_sel[i] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion and response
  // ---------------------------------------------------------------------------
  // PREADY is combinational so a zero-wait slave finishes in the first access
  // cycle. A setup phase never completes, and PENABLE seen in IDLE (no prior
  // setup) is not an access.
  assign w_access = (r_state == ACCESS) && PSEL && PENABLE;
  assign w_done   = w_access && (r_cnt == '0);
  assign w_commit = w_done && PWRITE && !w_err;

  assign PREADY  = w_done;
  assign PSLVERR = w_done && w_err;

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_sel[i]) w_rdata = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : r_regs[i];
    end
  end

  // The data bus stays quiet except on a successful read completion.
  assign PRDATA = (w_done && !PWRITE && !w_err) ? w_rdata : '0;

  // ---------------------------------------------------------------------------
  // Transfer FSM and wait counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            r_state <= ACCESS;
            r_cnt   <= WAIT_INIT;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            // Master walked away: abandon the transfer without committing.
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (PENABLE) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            else             r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and write pulses
  // ---------------------------------------------------------------------------
  // NOTE: the register array is reset explicitly because its contents are
  // architecturally visible on reg_q; a RAM-style unreset array would leave
  // configuration outputs undefined after reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      // A strobe-less write (PSTRB=0) still counts as a successful write.
      r_wr_pulse <= w_commit ? w_sel : '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit && w_sel[i]) begin
          for (int b = 0; b < NB; b++) begin
            if (w_strb[b]) r_regs[i][b*8 +: 8] <= PWDATA[b*8 +: 8];
          end
        end
      end
    end
  end

  // RO slots are never written, so their flops stay constant; they are masked
  // here so downstream logic only ever sees configuration values.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : r_regs[i];
    end
  end

  assign wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_apb_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_reg_slave
// Two instances share the bus signals except PSEL: u_dut0 has no wait states,
// u_dut3 has three. Both mark register 7 read-only. Vectors are applied to
// u_dut0 from a table; wait-state, abort and reset corners use u_dut3.
// -----------------------------------------------------------------------------
module tb_apb_reg_slave;

  localparam int             AW  = 12;
  localparam int             DW  = 32;
  localparam int             NR  = 8;
  localparam logic [NR-1:0]  ROM = 8'h80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              psel0, psel3, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
`ifdef APB_REG_SLAVE_PSTRB_EN
  logic [DW/8-1:0]   pstrb;
`endif
  logic [DW-1:0]     prdata0, prdata3;
  logic              pready0, pready3, pslverr0, pslverr3;
  logic [NR*DW-1:0]  hw_status, reg_q0, reg_q3;
  logic [NR-1:0]     wr_pulse0, wr_pulse3;

  apb_reg_slave #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .BASE_ADDR(0),
    .WAIT_CYCLES(0), .RO_MASK(ROM)
  ) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_REG_SLAVE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
    .hw_status(hw_status), .reg_q(reg_q0), .wr_pulse(wr_pulse0)
  );

  apb_reg_slave #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .BASE_ADDR(0),
    .WAIT_CYCLES(3), .RO_MASK(ROM)
  ) u_dut3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel3), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_REG_SLAVE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
    .hw_status(hw_status), .reg_q(reg_q3), .wr_pulse(wr_pulse3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Full APB transfer. Called at posedge+1 with the bus idle; drives the setup
  // phase immediately, so consecutive calls are back-to-back. Returns at
  // posedge+1 after the completing edge with the bus idle. cycles = number of
  // access-phase cycles until PREADY, or -1 if it never came.
  task automatic xfer(input bit which, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, output int cycles,
                      output logic err, output logic [DW-1:0] rdata);
    bit got;
    got    = 1'b0;
    cycles = -1;
    err    = 1'b0;
    rdata  = '0;
    if (which) psel3 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if ((which ? pready3 : pready0) === 1'b1) begin
        got    = 1'b1;
        cycles = c;
        err    = which ? pslverr3 : pslverr0;
        rdata  = which ? prdata3 : prdata0;
      end
      @(posedge clk); #1;
    end
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
    logic [NR-1:0] exp_pulse;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cyc;
    logic          err;
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_slot [NR];

    //            wr  addr     wdata          err  rdata          pulse
    vecs[0]  = '{1, 12'h004, 32'hDEADBEEF, 0, 32'h0,        8'h02};
    vecs[1]  = '{0, 12'h004, 32'h0,        0, 32'hDEADBEEF, 8'h00};
    vecs[2]  = '{1, 12'h002, 32'h11111111, 1, 32'h0,        8'h00};  // misaligned
    vecs[3]  = '{1, 12'h020, 32'h22222222, 1, 32'h0,        8'h00};  // out of range
    vecs[4]  = '{1, 12'h01C, 32'h33333333, 1, 32'h0,        8'h00};  // RO reg 7
    vecs[5]  = '{0, 12'h01C, 32'h0,        0, 32'hCAFE0007, 8'h00};  // RO read
    vecs[6]  = '{0, 12'h004, 32'h0,        0, 32'hDEADBEEF, 8'h00};
    vecs[7]  = '{0, 12'h020, 32'h0,        1, 32'h0,        8'h00};
    vecs[8]  = '{1, 12'h008, 32'hA5A5A5A5, 0, 32'h0,        8'h04};
    vecs[9]  = '{0, 12'h008, 32'h0,        0, 32'hA5A5A5A5, 8'h00};
    vecs[10] = '{0, 12'h000, 32'h0,        0, 32'h0,        8'h00};
    vecs[11] = '{0, 12'h003, 32'h0,        1, 32'h0,        8'h00};
    vecs[12] = '{1, 12'h018, 32'h00000066, 0, 32'h0,        8'h40};
    vecs[13] = '{0, 12'h018, 32'h0,        0, 32'h00000066, 8'h00};
    vecs[14] = '{1, 12'hFFC, 32'h44444444, 1, 32'h0,        8'h00};

    for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = 32'hCAFE0000 | 32'(i);
`ifdef APB_REG_SLAVE_PSTRB_EN
    pstrb = '1;
`endif

    // ---- Reset with arbitrary bus activity ----
    rst_n   = 1'b0;
    psel0   = 1'b1;
    psel3   = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 12'h004;
    pwdata  = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready0",  64'(pready0),  64'd0);
    check("rst_pslverr0", 64'(pslverr0), 64'd0);
    check("rst_prdata0",  64'(prdata0),  64'd0);
    check("rst_regq0",    64'(|reg_q0),  64'd0);
    check("rst_pulse0",   64'(wr_pulse0), 64'd0);
    check("rst_pready3",  64'(pready3),  64'd0);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- Table-driven zero-wait transfers ----
    for (int i = 0; i < 15; i++) begin
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, cyc, err, rd);
      check($sformatf("v%0d_cycles", i), 64'(cyc),  64'd1);
      check($sformatf("v%0d_err", i),    64'(err),  64'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata", i),  64'(rd),   64'(vecs[i].exp_rdata));
      check($sformatf("v%0d_pulse", i),  64'(wr_pulse0), 64'(vecs[i].exp_pulse));
    end

    exp_slot = '{32'h0, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0,
                 32'h0, 32'h0,        32'h00000066, 32'h0};
    for (int i = 0; i < NR; i++)
      check($sformatf("regq0_slot%0d", i), 64'(reg_q0[i*DW +: DW]), 64'(exp_slot[i]));

    // ---- wr_pulse lasts exactly one cycle ----
    xfer(1'b0, 1'b1, 12'h00C, 32'h0C0C0C0C, cyc, err, rd);
    check("pw_pulse_hi", 64'(wr_pulse0), 64'h08);
    check("pw_regq3",    64'(reg_q0[3*DW +: DW]), 64'h0C0C0C0C);
    @(posedge clk); #1;
    check("pw_pulse_lo", 64'(wr_pulse0), 64'h00);

    // ---- PENABLE without setup phase is ignored ----
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h99;
    @(negedge clk);
    check("nosetup_pready_a", 64'(pready0), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("nosetup_pready_b", 64'(pready0), 64'd0);
    @(posedge clk); #1;
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("nosetup_reg0",  64'(reg_q0[0 +: DW]), 64'd0);
    check("nosetup_pulse", 64'(wr_pulse0), 64'd0);

    // ---- Three wait states ----
    xfer(1'b1, 1'b1, 12'h000, 32'h12345678, cyc, err, rd);
    check("w3_wr_cycles", 64'(cyc), 64'd4);
    check("w3_wr_err",    64'(err), 64'd0);
    check("w3_wr_reg0",   64'(reg_q3[0 +: DW]), 64'h12345678);
    check("w3_wr_pulse",  64'(wr_pulse3), 64'h01);
    xfer(1'b1, 1'b0, 12'h000, 32'h0, cyc, err, rd);
    check("w3_rd_cycles", 64'(cyc), 64'd4);
    check("w3_rd_data",   64'(rd),  64'h12345678);

    // ---- Abort during wait states ----
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h55;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_pready_a", 64'(pready3), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_pready_b", 64'(pready3), 64'd0);
    @(posedge clk); #1;
    psel3 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("abort_pulse", 64'(wr_pulse3), 64'd0);
    check("abort_reg1",  64'(reg_q3[1*DW +: DW]), 64'd0);
    xfer(1'b1, 1'b0, 12'h004, 32'h0, cyc, err, rd);
    check("abort_rd_cycles", 64'(cyc), 64'd4);
    check("abort_rd_data",   64'(rd),  64'd0);

    // ---- Reset asserted mid-access ----
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_pready", 64'(pready3), 64'd0);
    check("midrst_regq3",  64'(|reg_q3), 64'd0);
    check("midrst_pulse",  64'(wr_pulse3), 64'd0);
    @(posedge clk); #1;
    psel3 = 1'b0; penable = 1'b0;
    check("midrst_reg2_held", 64'(reg_q3[2*DW +: DW]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b1, 1'b1, 12'h008, 32'h77, cyc, err, rd);
    check("postrst_wr_cycles", 64'(cyc), 64'd4);
    check("postrst_wr_err",    64'(err), 64'd0);
    xfer(1'b1, 1'b0, 12'h008, 32'h0, cyc, err, rd);
    check("postrst_rd_data",   64'(rd),  64'h77);

`ifdef APB_REG_SLAVE_PSTRB_EN
    // ---- Byte strobes ----
    pstrb = 4'hF;
    xfer(1'b0, 1'b1, 12'h010, 32'hFFFFFFFF, cyc, err, rd);
    pstrb = 4'b0101;
    xfer(1'b0, 1'b1, 12'h010, 32'h00000000, cyc, err, rd);
    check("strb_err", 64'(err), 64'd0);
    pstrb = 4'b0000;
    xfer(1'b0, 1'b1, 12'h010, 32'h12345678, cyc, err, rd);
    check("strb0_err",   64'(err), 64'd0);
    check("strb0_pulse", 64'(wr_pulse0), 64'h10);
    xfer(1'b0, 1'b0, 12'h010, 32'h0, cyc, err, rd);
    check("strb_rdata", 64'(rd), 64'hFF00FF00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
